// File: rtl/vga_sync_rx.sv
// VGA timing receiver: measures the incoming hsync/vsync cadence, locks onto a
// conforming stream and regenerates pixel_x/pixel_y/video_on locally.
module vga_sync_rx #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int HD           = 640,
  parameter int VD           = 480,
  parameter int H_SYNC_START = 656,
  parameter int V_SYNC_START = 513,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        err_clr,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        locked,
  output logic        err_sticky,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCK   = 2'd2;

  localparam logic [10:0] CNT_MAX         = 11'h7ff;
  localparam logic [10:0] LINE_TICKS      = 11'(H_TOTAL);
  localparam logic [10:0] LINES_PER_FRAME = 11'(V_TOTAL);
  localparam logic [10:0] TIMEOUT_TICKS   = 11'(2 * H_TOTAL);
  localparam logic [9:0]  X_LAST          = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST          = 10'(V_TOTAL - 1);
  localparam logic [9:0]  X_AT_HRISE      = 10'(H_SYNC_START + 1);
  localparam logic [9:0]  Y_AT_VRISE      = 10'(V_SYNC_START);
  localparam logic [9:0]  X_DISP          = 10'(HD);
  localparam logic [9:0]  Y_DISP          = 10'(VD);
  localparam logic [1:0]  GOOD_TARGET     = 2'(LOCK_FRAMES);

  logic        hs_q_reg, hs_q_next;
  logic        vs_q_reg, vs_q_next;
  logic [10:0] lcnt_reg, lcnt_next;
  logic [10:0] fcnt_reg, fcnt_next;
  logic [10:0] line_len_reg, line_len_next;
  logic [10:0] frame_lines_reg, frame_lines_next;
  logic [9:0]  px_reg, px_next;
  logic [9:0]  py_reg, py_next;
  logic [1:0]  state_reg, state_next;
  logic [1:0]  good_cnt_reg, good_cnt_next;
  logic        bad_line_reg, bad_line_next;
  logic        seen_line_reg, seen_line_next;
  logic        locked_reg, locked_next;
  logic        video_on_reg, video_on_next;
  logic        err_sticky_reg, err_sticky_next;

  logic        h_rise, v_rise;
  logic [10:0] lcnt_inc, fcnt_inc;
  logic        line_bad, frame_good, timeout, lock_lost, x_wrap;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  assign h_rise   = p_tick & hsync & ~hs_q_reg;
  assign v_rise   = p_tick & vsync & ~vs_q_reg;
  assign lcnt_inc = sat_inc(lcnt_reg);
  // A coincident h_rise belongs to the frame that is closing.
  assign fcnt_inc = h_rise ? sat_inc(fcnt_reg) : fcnt_reg;

  // seen_line_reg=0 marks the partial line right after (re)entering SEARCH.
  assign line_bad   = h_rise & seen_line_reg & (lcnt_inc != LINE_TICKS);
  assign frame_good = (fcnt_inc == LINES_PER_FRAME) & ~bad_line_reg & ~line_bad;
  assign timeout    = p_tick & ~h_rise & (lcnt_inc >= TIMEOUT_TICKS);

  always_comb begin
    hs_q_next        = hs_q_reg;
    vs_q_next        = vs_q_reg;
    lcnt_next        = lcnt_reg;
    fcnt_next        = fcnt_reg;
    line_len_next    = line_len_reg;
    frame_lines_next = frame_lines_reg;
    if (p_tick) begin
      hs_q_next = hsync;
      vs_q_next = vsync;
      if (h_rise) begin
        line_len_next = lcnt_inc;
        lcnt_next     = '0;
      end else begin
        lcnt_next = lcnt_inc;
      end
      if (v_rise) begin
        frame_lines_next = fcnt_inc;
        fcnt_next        = '0;
      end else begin
        fcnt_next = fcnt_inc;
      end
    end
  end

  assign x_wrap = ~h_rise & (px_reg == X_LAST);

  always_comb begin
    px_next = px_reg;
    py_next = py_reg;
    if (p_tick) begin
      if (h_rise)
        px_next = X_AT_HRISE;
      else if (x_wrap)
        px_next = '0;
      else
        px_next = px_reg + 10'd1;

      if (v_rise)
        py_next = Y_AT_VRISE;
      else if (x_wrap)
        py_next = (py_reg == Y_LAST) ? 10'd0 : py_reg + 10'd1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    lock_lost     = 1'b0;
    case (state_reg)
      SEARCH: begin
        if (v_rise) begin
          state_next    = TRACK;
          good_cnt_next = '0;
        end
      end
      TRACK: begin
        if (timeout) begin
          state_next = SEARCH;
        end else if (v_rise) begin
          if (!frame_good) begin
            good_cnt_next = '0;
          end else if (good_cnt_reg + 2'd1 == GOOD_TARGET) begin
            state_next    = LOCK;
            good_cnt_next = '0;
          end else begin
            good_cnt_next = good_cnt_reg + 2'd1;
          end
        end
      end
      LOCK: begin
        if (timeout || line_bad || (v_rise && !frame_good)) begin
          state_next = SEARCH;
          lock_lost  = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    bad_line_next = bad_line_reg;
    if (v_rise)
      bad_line_next = 1'b0;
    else if (line_bad)
      bad_line_next = 1'b1;

    seen_line_next = seen_line_reg;
    if (state_reg != SEARCH && state_next == SEARCH)
      seen_line_next = 1'b0;
    else if (h_rise)
      seen_line_next = 1'b1;

    locked_next   = (state_next == LOCK);
    video_on_next = locked_next && (px_next < X_DISP) && (py_next < Y_DISP);

    // A lock loss wins over a simultaneous clear request.
    err_sticky_next = err_sticky_reg;
    if (lock_lost)
      err_sticky_next = 1'b1;
    else if (err_clr)
      err_sticky_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q_reg        <= 1'b0;
      vs_q_reg        <= 1'b0;
      lcnt_reg        <= '0;
      fcnt_reg        <= '0;
      line_len_reg    <= '0;
      frame_lines_reg <= '0;
      px_reg          <= '0;
      py_reg          <= '0;
      state_reg       <= SEARCH;
      good_cnt_reg    <= '0;
      bad_line_reg    <= 1'b0;
      seen_line_reg   <= 1'b0;
      locked_reg      <= 1'b0;
      video_on_reg    <= 1'b0;
      err_sticky_reg  <= 1'b0;
    end else begin
      hs_q_reg        <= hs_q_next;
      vs_q_reg        <= vs_q_next;
      lcnt_reg        <= lcnt_next;
      fcnt_reg        <= fcnt_next;
      line_len_reg    <= line_len_next;
      frame_lines_reg <= frame_lines_next;
      px_reg          <= px_next;
      py_reg          <= py_next;
      state_reg       <= state_next;
      good_cnt_reg    <= good_cnt_next;
      bad_line_reg    <= bad_line_next;
      seen_line_reg   <= seen_line_next;
      locked_reg      <= locked_next;
      video_on_reg    <= video_on_next;
      err_sticky_reg  <= err_sticky_next;
    end
  end

  assign pixel_x     = px_reg;
  assign pixel_y     = py_reg;
  assign video_on    = video_on_reg;
  assign locked      = locked_reg;
  assign err_sticky  = err_sticky_reg;
  assign line_len    = line_len_reg;
  assign frame_lines = frame_lines_reg;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a scaled-down 40x20 timing so whole frames stay short.
module tb_vga_sync_rx;

  localparam int H     = 40;
  localparam int V     = 20;
  localparam int HDISP = 32;
  localparam int VDISP = 15;
  localparam int HS0   = 33;
  localparam int HSW   = 4;
  localparam int VS0   = 16;
  localparam int VSW   = 2;

  logic        clk = 1'b0;
  logic        reset, p_tick, hsync, vsync, err_clr;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, locked, err_sticky;
  logic [10:0] line_len, frame_lines;

  int checks = 0;
  int passes = 0;
  int prints = 0;

  // generator state: hc/vc are the position of the tick about to be driven
  int hc = 0, vc = 0, vtot = V, stretch_line = -1;
  bit hmask = 1'b0, clr_req = 1'b0;

  vga_sync_rx #(
    .H_TOTAL(H), .V_TOTAL(V), .HD(HDISP), .VD(VDISP),
    .H_SYNC_START(HS0), .V_SYNC_START(VS0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .err_clr(err_clr), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .locked(locked), .err_sticky(err_sticky), .line_len(line_len), .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  task automatic tick();
    int lt;
    @(negedge clk);
    hsync   = !hmask && (hc >= HS0) && (hc < HS0 + HSW);
    vsync   = (vc >= VS0) && (vc < VS0 + VSW);
    p_tick  = 1'b1;
    err_clr = clr_req;
    @(posedge clk);
    lt = (vc == stretch_line) ? H + 1 : H;
    if (hc >= lt - 1) begin
      hc = 0;
      vc = (vc >= vtot - 1) ? 0 : vc + 1;
    end else begin
      hc = hc + 1;
    end
    #1;
    p_tick  = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic tick_until(input int thc, input int tvc);
    int n;
    n = 0;
    while (!(hc == thc && vc == tvc) && n < 4000) begin
      tick();
      n++;
    end
    if (!(hc == thc && vc == tvc)) begin
      checks++;
      $display("FAIL tick_until: position %0d,%0d expected %0d,%0d", hc, vc, thc, tvc);
    end
  endtask

  task automatic vrise();
    tick_until(0, VS0);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pixel_x !== 10'd0) $display("FAIL rst_pixel_x: got %0d expected 0", pixel_x); else passes++;
    checks++; if (pixel_y !== 10'd0) $display("FAIL rst_pixel_y: got %0d expected 0", pixel_y); else passes++;
    checks++; if (video_on !== 1'b0) $display("FAIL rst_video_on: got %0b expected 0", video_on); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL rst_locked: got %0b expected 0", locked); else passes++;
    checks++; if (err_sticky !== 1'b0) $display("FAIL rst_err_sticky: got %0b expected 0", err_sticky); else passes++;
    checks++; if (line_len !== 11'd0) $display("FAIL rst_line_len: got %0d expected 0", line_len); else passes++;
    checks++; if (frame_lines !== 11'd0) $display("FAIL rst_frame_lines: got %0d expected 0", frame_lines); else passes++;
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_nominal();
    logic exp_von;
    vrise();
    checks++; if (locked !== 1'b0) $display("FAIL nom_vrise1_locked: got %0b expected 0", locked); else passes++;
    vrise();
    checks++; if (locked !== 1'b0) $display("FAIL nom_vrise2_locked: got %0b expected 0", locked); else passes++;
    vrise();
    checks++; if (locked !== 1'b1) $display("FAIL nom_vrise3_locked: got %0b expected 1", locked); else passes++;
    checks++; if (line_len !== 11'd40) $display("FAIL nom_line_len: got %0d expected 40", line_len); else passes++;
    checks++; if (frame_lines !== 11'd20) $display("FAIL nom_frame_lines: got %0d expected 20", frame_lines); else passes++;
    for (int i = 0; i < H * V; i++) begin
      tick();
      exp_von = (hc < HDISP) && (vc < VDISP);
      checks++;
      if (pixel_x !== hc[9:0] || pixel_y !== vc[9:0] || video_on !== exp_von || locked !== 1'b1) begin
        if (prints < 8)
          $display("FAIL nom_stream: got x=%0d y=%0d von=%0b lk=%0b expected x=%0d y=%0d von=%0b lk=1",
                   pixel_x, pixel_y, video_on, locked, hc, vc, exp_von);
        prints++;
      end else passes++;
    end
    $display("test_nominal done");
  endtask

  task automatic test_stretch();
    stretch_line = 5;
    tick_until(HS0, 6);
    checks++; if (locked !== 1'b1) $display("FAIL str_pre_locked: got %0b expected 1", locked); else passes++;
    tick();
    stretch_line = -1;
    checks++; if (locked !== 1'b0) $display("FAIL str_locked: got %0b expected 0", locked); else passes++;
    checks++; if (err_sticky !== 1'b1) $display("FAIL str_err_sticky: got %0b expected 1", err_sticky); else passes++;
    checks++; if (line_len !== 11'd41) $display("FAIL str_line_len: got %0d expected 41", line_len); else passes++;
    vrise();
    checks++; if (locked !== 1'b0) $display("FAIL str_relock_v1: got %0b expected 0", locked); else passes++;
    vrise();
    checks++; if (locked !== 1'b0) $display("FAIL str_relock_v2: got %0b expected 0", locked); else passes++;
    vrise();
    checks++; if (locked !== 1'b1) $display("FAIL str_relock_v3: got %0b expected 1", locked); else passes++;
    checks++; if (err_sticky !== 1'b1) $display("FAIL str_err_held: got %0b expected 1", err_sticky); else passes++;
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    checks++; if (err_sticky !== 1'b0) $display("FAIL str_err_clr: got %0b expected 0", err_sticky); else passes++;
    $display("test_stretch done");
  endtask

  task automatic test_timeout();
    tick_until(HS0 + 1, 3);
    hmask = 1'b1;
    repeat (2 * H - 1) tick();
    checks++; if (locked !== 1'b1) $display("FAIL to_pre_locked: got %0b expected 1", locked); else passes++;
    tick();
    checks++; if (locked !== 1'b0) $display("FAIL to_locked: got %0b expected 0", locked); else passes++;
    checks++; if (err_sticky !== 1'b1) $display("FAIL to_err_sticky: got %0b expected 1", err_sticky); else passes++;
    hmask = 1'b0;
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    checks++; if (err_sticky !== 1'b0) $display("FAIL to_err_clr_idle: got %0b expected 0", err_sticky); else passes++;
    vrise(); vrise(); vrise();
    checks++; if (locked !== 1'b1) $display("FAIL to_relock: got %0b expected 1", locked); else passes++;
    $display("test_timeout done");
  endtask

  task automatic test_ptick_pause();
    logic exp_von;
    tick_until(10, 4);
    @(negedge clk);
    hsync = 1'b1; vsync = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    checks++; if (pixel_x !== 10'd10) $display("FAIL pause_pixel_x: got %0d expected 10", pixel_x); else passes++;
    checks++; if (pixel_y !== 10'd4) $display("FAIL pause_pixel_y: got %0d expected 4", pixel_y); else passes++;
    checks++; if (locked !== 1'b1) $display("FAIL pause_locked: got %0b expected 1", locked); else passes++;
    checks++; if (video_on !== 1'b1) $display("FAIL pause_video_on: got %0b expected 1", video_on); else passes++;
    checks++; if (line_len !== 11'd40) $display("FAIL pause_line_len: got %0d expected 40", line_len); else passes++;
    for (int i = 0; i < H * V; i++) begin
      tick();
      exp_von = (hc < HDISP) && (vc < VDISP);
      checks++;
      if (pixel_x !== hc[9:0] || pixel_y !== vc[9:0] || video_on !== exp_von || locked !== 1'b1) begin
        if (prints < 8)
          $display("FAIL pause_resume: got x=%0d y=%0d von=%0b lk=%0b expected x=%0d y=%0d von=%0b lk=1",
                   pixel_x, pixel_y, video_on, locked, hc, vc, exp_von);
        prints++;
      end else passes++;
    end
    $display("test_ptick_pause done");
  endtask

  task automatic test_reset_midframe();
    tick_until(10, 5);
    #2 reset = 1'b1;
    #1;
    checks++; if (locked !== 1'b0) $display("FAIL mid_rst_locked: got %0b expected 0", locked); else passes++;
    checks++; if (video_on !== 1'b0) $display("FAIL mid_rst_video_on: got %0b expected 0", video_on); else passes++;
    checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0)
      $display("FAIL mid_rst_pixel: got %0d,%0d expected 0,0", pixel_x, pixel_y); else passes++;
    checks++; if (line_len !== 11'd0 || frame_lines !== 11'd0)
      $display("FAIL mid_rst_meas: got %0d,%0d expected 0,0", line_len, frame_lines); else passes++;
    repeat (5) tick();
    @(negedge clk);
    reset = 1'b0;
    vrise();
    checks++; if (locked !== 1'b0) $display("FAIL mid_v1_locked: got %0b expected 0", locked); else passes++;
    vrise();
    checks++; if (locked !== 1'b0) $display("FAIL mid_v2_locked: got %0b expected 0", locked); else passes++;
    vrise();
    checks++; if (locked !== 1'b1) $display("FAIL mid_v3_locked: got %0b expected 1", locked); else passes++;
    $display("test_reset_midframe done");
  endtask

  task automatic test_short_frame();
    tick_until(10, 5);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    vrise();
    vtot = V - 1;
    vrise();
    vtot = V;
    checks++; if (frame_lines !== 11'd19) $display("FAIL short_frame_lines: got %0d expected 19", frame_lines); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL short_locked: got %0b expected 0", locked); else passes++;
    vrise();
    checks++; if (locked !== 1'b0) $display("FAIL short_good1_locked: got %0b expected 0", locked); else passes++;
    vrise();
    checks++; if (locked !== 1'b1) $display("FAIL short_good2_locked: got %0b expected 1", locked); else passes++;
    $display("test_short_frame done");
  endtask

  task automatic test_errclr_coincide();
    checks++; if (err_sticky !== 1'b0) $display("FAIL co_err_base: got %0b expected 0", err_sticky); else passes++;
    stretch_line = 5;
    tick_until(HS0, 6);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    stretch_line = -1;
    checks++; if (locked !== 1'b0) $display("FAIL co_locked: got %0b expected 0", locked); else passes++;
    checks++; if (err_sticky !== 1'b1) $display("FAIL co_err_sticky: got %0b expected 1", err_sticky); else passes++;
    $display("test_errclr_coincide done");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stretch();
    test_timeout();
    test_ptick_pause();
    test_reset_midframe();
    test_short_frame();
    test_errclr_coincide();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receiving end of the 640x480 VGA timing interface.
- Samples a hsync/vsync pair on the pixel-enable tick and measures line length and lines per frame.
- Locks onto a conforming timing stream, then regenerates pixel_x/pixel_y/video_on locally.
- Used to check and re-align pixel pipelines fed by the sync generator, and as a self-check monitor in test builds.

Parameters:
- H_TOTAL, 800, pixel ticks per line
- V_TOTAL, 525, lines per frame
- HD, 640, horizontal display width
- VD, 480, vertical display height
- H_SYNC_START, 656, pixel index of the hsync rising edge
- V_SYNC_START, 513, line index of the vsync rising edge
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..3)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p_tick  in  1  pixel enable, one clk wide; all sampling and counting happens only when p_tick=1
- hsync  in  1  horizontal sync, active-high
- vsync  in  1  vertical sync, active-high
- err_clr  in  1  clears err_sticky (sampled every clk)
- pixel_x  out  10  recovered column
- pixel_y  out  10  recovered row
- video_on  out  1  locked && pixel_x<HD && pixel_y<VD
- locked  out  1  timing lock achieved
- err_sticky  out  1  set when lock is lost
- line_len  out  11  last measured hsync-to-hsync tick count
- frame_lines  out  11  last measured vsync-to-vsync line count

Behaviour:
- Reset (async, active-high) clears:
  - all registers;
  - outputs: pixel_x=0, pixel_y=0, video_on=0, locked=0, err_sticky=0, line_len=0, frame_lines=0;
  - state=SEARCH.
- Input sampling, on p_tick only:
  - hs_q<=hsync, vs_q<=vsync.
  - h_rise = p_tick & hsync & ~hs_q; v_rise = p_tick & vsync & ~vs_q.
- Counters, all 11-bit, saturating at 2047:
  - lcnt: ticks since last h_rise. On h_rise, line_len<=lcnt+1 and lcnt<=0; else lcnt+1 on each tick.
  - fcnt: h_rise count since last v_rise. On v_rise, frame_lines<=fcnt and fcnt<=0.
  - If h_rise and v_rise coincide, the line count is taken before the reset, i.e. frame_lines includes that line.
- Position regeneration, per tick:
  - Horizontal: on h_rise, pixel_x<=H_SYNC_START+1; otherwise pixel_x increments, wrapping H_TOTAL-1 -> 0.
  - Vertical: on v_rise, pixel_y<=V_SYNC_START. Otherwise, when pixel_x wraps to 0, pixel_y increments, wrapping V_TOTAL-1 -> 0.
  - Counters free-run in all states; they are valid only when locked=1.
- line_good: h_rise with line_len_next==H_TOTAL. The first h_rise after entering SEARCH is ignored (partial line; tracked by flag first_line).
- frame_good: v_rise with fcnt==V_TOTAL and no bad line since the previous v_rise.
- Lock FSM:
  - SEARCH: locked=0. On v_rise -> TRACK, good_cnt=0, clear bad-line flag.
  - TRACK, on v_rise:
    - if frame_good, good_cnt+1; if good_cnt+1==LOCK_FRAMES -> LOCKED.
    - if not frame_good, good_cnt=0 and stay in TRACK.
    - A bad line in TRACK only marks the current frame bad.
  - LOCKED: locked=1.
    - Any bad line (h_rise, not first_line, line_len_next!=H_TOTAL) or bad v_rise -> SEARCH, err_sticky<=1.
  - Timeout: in TRACK or LOCKED, lcnt reaching 2*H_TOTAL -> SEARCH. Also sets err_sticky if the block was LOCKED.
- locked and video_on are registered and change the clk after the deciding tick.
- err_sticky: set has priority over err_clr in the same clk.
- p_tick=0: every register holds except err_sticky, which is still cleared by err_clr.
- Reset mid-frame: everything returns to SEARCH immediately; no output glitch beyond the async clear.

Test Plan:
- Nominal 800x525 stream, hsync ticks 656-751, vsync lines 513-514:
  - locked=1 one clk after the 3rd v_rise;
  - then line_len=800 and frame_lines=525;
  - pixel_x/pixel_y match the generator's counters every tick;
  - video_on matches the generator's video_on.
- Locked, one line stretched to 801 ticks -> at that h_rise, state SEARCH, locked=0, err_sticky=1, line_len=801; relock after 3 further v_rise.
- Locked, hsync held low -> after 1600 ticks, locked=0 and err_sticky=1; err_clr pulse -> err_sticky=0.
- Frame with 524 lines in TRACK -> good_cnt resets, no lock at that edge; lock on the 2nd subsequent good frame.
- p_tick held low for 1000 clk mid-line -> no counter or state change; stream resumes without lock loss.
- reset asserted mid-frame while locked -> all outputs 0 asynchronously; after release, lock takes 3 v_rise again.
- err_clr asserted in the same clk as a lock-loss event -> err_sticky=1.
